// File: rtl/pdm_pkg.sv
// Shared PDM definitions: full-scale constant, integrator saturation and pdm_clk phase naming.
// Also used by the cic PDM-microphone decimator.
package pdm_pkg;

  typedef logic signed [63:0] wide_t;

  typedef enum logic {
    PH_LEFT,
    PH_RIGHT
  } pdm_phase_e;

  // Full-scale feedback magnitude, 2^(width-1).
  function automatic wide_t fs(input int unsigned width);
    return wide_t'(1) <<< (width - 1);
  endfunction

  // Symmetric clamp to +/-(2^(acc_w-1)-1).
  function automatic wide_t sat(input wide_t v, input int unsigned acc_w);
    wide_t lim;
    lim = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pdm_modulator_if.sv
// PCM sample-pair handshake between a PCM source and the PDM modulator.
interface pdm_modulator_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0] pcm_l;
  logic [WIDTH-1:0] pcm_r;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (
    output pcm_l,
    output pcm_r,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_l,
    input  pcm_r,
    input  pcm_valid,
    output pcm_ready
  );

endinterface

// File: rtl/pdm_modulator_sd2.sv
// One second-order sigma-delta modulator channel; state advances only on step.
// step_bit is the bit produced by the step taken this cycle.
module sd2_channel
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ACC_W = WIDTH + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic signed [WIDTH-1:0] sample,
  output logic                    step_bit
);

  localparam wide_t Fs = fs(WIDTH);

  logic signed [ACC_W-1:0] i1_q, i2_q;
  logic signed [ACC_W-1:0] i1_d, i2_d;
  logic                    last_bit_q;
  wide_t                   fb;

  always_comb begin
    fb       = last_bit_q ? Fs : -Fs;
    i1_d     = ACC_W'(sat(wide_t'(i1_q) + wide_t'(sample) - fb, ACC_W));
    i2_d     = ACC_W'(sat(wide_t'(i2_q) + wide_t'(i1_d) - fb, ACC_W));
    step_bit = ~i2_d[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q       <= '0;
      i2_q       <= '0;
      last_bit_q <= 1'b0;
    end else if (step) begin
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      last_bit_q <= step_bit;
    end
  end

endmodule

// File: rtl/pdm_modulator.sv
// Stereo PCM-to-PDM transmitter: one-entry PCM buffer, pdm_clk divider and two
// sigma-delta channels sharing one data line (left in the high half of pdm_clk).
module pdm_modulator
  import pdm_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned OSR      = 64,
  parameter int unsigned ACC_W    = WIDTH + 4
) (
  input  logic           clk,
  input  logic           reset,
  pdm_modulator_if.slave pcm,
  output logic           pdm_clk,
  output logic           pdm_dout,
  output logic           frame,
  output logic           underrun,
  input  logic           underrun_clr
);

  localparam int unsigned DW = $clog2(2 * HALF_DIV);
  localparam int unsigned BW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DW-1:0] DLast  = DW'(2 * HALF_DIV - 1);
  localparam logic [DW-1:0] DRight = DW'(HALF_DIV);
  localparam logic [BW-1:0] BLast  = BW'(OSR - 1);

  logic [DW-1:0]    dcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic             pdm_clk_q, pdm_dout_q, underrun_q, buf_full_q;
  logic [WIDTH-1:0] buf_l_q, buf_r_q, cur_l_q, cur_r_q;

  pdm_phase_e       phase;
  logic             left_step, right_step, boundary, load, accept;
  logic [WIDTH-1:0] sample_l;
  logic             bit_l, bit_r;

  always_comb begin
    phase      = (dcnt_q < DRight) ? PH_LEFT : PH_RIGHT;
    left_step  = (dcnt_q == '0);
    right_step = (dcnt_q == DRight);
    boundary   = left_step && (bcnt_q == '0);
    load       = boundary && buf_full_q;
    accept     = pcm.pcm_valid && !buf_full_q;
    // The left step at a boundary already runs on the freshly loaded sample.
    sample_l   = load ? buf_l_q : cur_l_q;
  end

  sd2_channel #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_sd_l (
    .clk      (clk),
    .reset    (reset),
    .step     (left_step),
    .sample   (sample_l),
    .step_bit (bit_l)
  );

  sd2_channel #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_sd_r (
    .clk      (clk),
    .reset    (reset),
    .step     (right_step),
    .sample   (cur_r_q),
    .step_bit (bit_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_q     <= '0;
      bcnt_q     <= '0;
      pdm_clk_q  <= 1'b0;
      pdm_dout_q <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      cur_l_q    <= '0;
      cur_r_q    <= '0;
    end else begin
      dcnt_q    <= (dcnt_q == DLast) ? '0 : dcnt_q + 1'b1;
      pdm_clk_q <= (phase == PH_LEFT);
      if (left_step) begin
        bcnt_q     <= (bcnt_q == BLast) ? '0 : bcnt_q + 1'b1;
        pdm_dout_q <= bit_l;
      end else if (right_step) begin
        pdm_dout_q <= bit_r;
      end
      // load needs a full buffer and accept an empty one, so they never collide.
      if (load) begin
        cur_l_q    <= buf_l_q;
        cur_r_q    <= buf_r_q;
        buf_full_q <= 1'b0;
      end
      if (accept) begin
        buf_l_q    <= pcm.pcm_l;
        buf_r_q    <= pcm.pcm_r;
        buf_full_q <= 1'b1;
      end
      if (underrun_clr) begin
        underrun_q <= 1'b0;
      end else if (boundary && !buf_full_q) begin
        underrun_q <= 1'b1;
      end
    end
  end

  assign pcm.pcm_ready = ~buf_full_q;
  assign pdm_clk       = pdm_clk_q;
  assign pdm_dout      = pdm_dout_q;
  assign underrun      = underrun_q;
  assign frame         = boundary && !reset;

endmodule

// File: tb/tb_pdm_modulator.sv
// Bench for pdm_modulator: cycle-indexed behavioural model compared on every cycle,
// plus literal checks on reset values, bit densities, timing and underrun handling.
module tb_pdm_modulator;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int OSR = 64;
  localparam int ACC = W + 4;
  localparam int P   = 2 * H * OSR;
  localparam longint FSV = 64'sd32768;
  localparam longint LIM = (64'sd1 <<< (ACC - 1)) - 64'sd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic underrun_clr = 1'b0;
  logic pdm_clk, pdm_dout, frame, underrun;

  pdm_modulator_if #(.WIDTH(W)) pcm_if ();

  pdm_modulator #(
    .WIDTH    (W),
    .HALF_DIV (H),
    .OSR      (OSR),
    .ACC_W    (ACC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pcm          (pcm_if),
    .pdm_clk      (pdm_clk),
    .pdm_dout     (pdm_dout),
    .frame        (frame),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_rng(input string name, input longint act, input longint lo,
                           input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // Model: k = clk cycles since the last reset edge; steps and boundaries follow from k.
  bit      m_valid = 1'b0;
  longint  k = 0;
  bit      m_full, m_dout, m_under;
  shortint buf_l, buf_r, cur_l, cur_r;
  longint  i1 [2];
  longint  i2 [2];
  bit      lb [2];

  // Observed statistics.
  longint cyc = 0, last_frame_cyc = -1, frame_gap = 0, last_rise = -1, clk_period = 0;
  int     n_l = 0, c_l = 0, last_l = 0, n_r = 0, c_r = 0, last_r = 0;
  int     acc_cnt = 0, last_acc = 0;
  bit     prev_clk = 1'b0;

  function automatic longint clamp(input longint v);
    if (v > LIM) return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic sd_step(input int ch, input shortint s);
    longint x, fb;
    x      = longint'(s);
    fb     = lb[ch] ? FSV : -FSV;
    i1[ch] = clamp(i1[ch] + x - fb);
    i2[ch] = clamp(i2[ch] + i1[ch] - fb);
    lb[ch] = (i2[ch] >= 0);
    m_dout = lb[ch];
  endtask

  task automatic model_step();
    bit     rdy, set_u;
    longint ph;
    if (reset) begin
      m_valid = 1'b1;
      k = 0;
      m_full = 0; m_dout = 0; m_under = 0;
      buf_l = 0; buf_r = 0; cur_l = 0; cur_r = 0;
      for (int c = 0; c < 2; c++) begin
        i1[c] = 0; i2[c] = 0; lb[c] = 0;
      end
      n_l = 0; c_l = 0; n_r = 0; c_r = 0; acc_cnt = 0;
      last_frame_cyc = -1; last_rise = -1;
      return;
    end
    rdy   = !m_full;
    set_u = 1'b0;
    ph    = k % (2 * H);
    if (ph == 0) begin
      if (k % P == 0) begin
        if (m_full) begin
          cur_l = buf_l; cur_r = buf_r; m_full = 0;
        end else begin
          set_u = 1'b1;
        end
      end
      sd_step(0, cur_l);
    end else if (ph == H) begin
      sd_step(1, cur_r);
    end
    if (underrun_clr) m_under = 0;
    else if (set_u) m_under = 1;
    if (pcm_if.pcm_valid && rdy) begin
      buf_l = pcm_if.pcm_l; buf_r = pcm_if.pcm_r; m_full = 1;
    end
    k++;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (m_valid) begin
      check("pdm_clk", pdm_clk, (k == 0) ? 0 : (((k - 1) % (2 * H)) < H));
      check("pdm_dout", pdm_dout, m_dout);
      check("frame", frame, (!reset && (k % P == 0)));
      check("pcm_ready", pcm_if.pcm_ready, !m_full);
      check("underrun", underrun, m_under);
      if (k > 0 && (k - 1) % (2 * H) == 0) begin
        c_l += int'(pdm_dout); n_l++;
        if (n_l == OSR) begin last_l = c_l; c_l = 0; n_l = 0; end
      end
      if (k > 0 && (k - 1) % (2 * H) == H) begin
        c_r += int'(pdm_dout); n_r++;
        if (n_r == OSR) begin last_r = c_r; c_r = 0; n_r = 0; end
      end
      if (frame) begin
        if (last_frame_cyc >= 0) frame_gap = cyc - last_frame_cyc;
        last_frame_cyc = cyc;
        last_acc = acc_cnt;
        acc_cnt = 0;
      end
      if (pcm_if.pcm_valid && pcm_if.pcm_ready) acc_cnt++;
      if (pdm_clk && !prev_clk) begin
        if (last_rise >= 0) clk_period = cyc - last_rise;
        last_rise = cyc;
      end
      prev_clk = pdm_clk;
    end
    model_step();
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the n-th frame pulse; a missing pulse is a failure.
  task automatic wait_frames(input int n);
    for (int f = 0; f < n; f++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (!frame && t < 2 * P) begin
        @(negedge clk);
        t++;
      end
      check("frame_timeout", frame, 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pcm_if.pcm_valid = 1'b1;
    pcm_if.pcm_l = '0;
    pcm_if.pcm_r = '0;
    reset = 1'b1;
    cyc_wait(3);
    check("rst_pdm_clk", pdm_clk, 0);
    check("rst_pdm_dout", pdm_dout, 0);
    check("rst_ready", pcm_if.pcm_ready, 1);
    check("rst_frame", frame, 0);
    check("rst_underrun", underrun, 0);
    reset = 1'b0;
    #1;
    check("first_frame", frame, 1);
    cyc_wait(1);
    check("first_left_bit", pdm_dout, 1);
    check("first_underrun", underrun, 1);
    check("ready_after_accept", pcm_if.pcm_ready, 0);
    cyc_wait(16);
    check("third_left_bit", pdm_dout, 0);
    underrun_clr = 1'b1;
    cyc_wait(1);
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);

    // Zero input
    wait_frames(2);
    check_rng("zero_ones_l", last_l, 31, 33);
    check_rng("zero_ones_r", last_r, 31, 33);
    check("pdm_clk_period", clk_period, 2 * H);
    check("frame_gap", frame_gap, P);
    check("accepts_per_frame", last_acc, 1);

    // +half / -half scale
    pcm_if.pcm_l = 16'h4000;
    pcm_if.pcm_r = 16'hC000;
    wait_frames(3);
    check_rng("half_ones_l", last_l, 46, 50);
    check_rng("half_ones_r", last_r, 14, 18);
    check("accepts_per_frame_b", last_acc, 1);

    // Source stops: underrun, previous sample repeats
    pcm_if.pcm_valid = 1'b0;
    wait_frames(1);
    check("underrun_set", underrun, 1);
    wait_frames(1);
    check_rng("repeat_ones_l", last_l, 46, 50);
    check_rng("repeat_ones_r", last_r, 14, 18);
    underrun_clr = 1'b1;
    cyc_wait(1);
    underrun_clr = 1'b0;
    check("underrun_clr_pulse", underrun, 0);
    // Clear coinciding with an empty boundary.
    repeat (P - 2) @(posedge clk);
    #1;
    check("at_boundary", frame, 1);
    underrun_clr = 1'b1;
    cyc_wait(1);
    underrun_clr = 1'b0;
    check("set_clr_priority", underrun, 0);

    // Full scale for 10 frames
    pcm_if.pcm_l = 16'h7FFF;
    pcm_if.pcm_r = 16'h7FFF;
    pcm_if.pcm_valid = 1'b1;
    wait_frames(2);
    for (int f = 0; f < 8; f++) begin
      wait_frames(1);
      check_rng("full_ones_l", last_l, 60, 64);
      check_rng("full_ones_r", last_r, 60, 64);
    end
    pcm_if.pcm_l = '0;
    pcm_if.pcm_r = '0;
    wait_frames(3);
    check_rng("recover_ones_l", last_l, 30, 34);
    check_rng("recover_ones_r", last_r, 30, 34);

    // Random traffic: sparse valids, random clears, full-range samples
    for (int i = 0; i < 6 * P; i++) begin
      pcm_if.pcm_valid = ($urandom_range(0, 399) == 0);
      pcm_if.pcm_l = 16'($urandom);
      pcm_if.pcm_r = 16'($urandom);
      underrun_clr = ($urandom_range(0, 299) == 0);
      cyc_wait(1);
    end
    underrun_clr = 1'b0;

    // Reset mid-frame with a full buffer
    pcm_if.pcm_valid = 1'b1;
    pcm_if.pcm_l = 16'h1234;
    pcm_if.pcm_r = 16'hF00D;
    wait_frames(1);
    cyc_wait(100);
    check("buffer_full_before_reset", pcm_if.pcm_ready, 0);
    pcm_if.pcm_valid = 1'b0;
    reset = 1'b1;
    cyc_wait(1);
    check("mid_rst_pdm_clk", pdm_clk, 0);
    check("mid_rst_pdm_dout", pdm_dout, 0);
    check("mid_rst_ready", pcm_if.pcm_ready, 1);
    check("mid_rst_frame", frame, 0);
    check("mid_rst_underrun", underrun, 0);
    reset = 1'b0;
    #1;
    check("mid_rst_first_frame", frame, 1);
    cyc_wait(1);
    check("buffer_discarded", underrun, 1);
    pcm_if.pcm_valid = 1'b1;
    wait_frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
